// File: rtl/mac_accum_multilane.sv
// Multi-lane MAC accumulate stage: sums K beats of LANES products into one C tile,
// then writes each finished tile to C memory over valid/ready and flags completion.
module mac_accum_multilane #(
  parameter int M                        = 4,
  parameter int K                        = 4,
  parameter int N                        = 4,
  parameter int LANES                    = 2,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int SIGNED                   = 1,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      start,
  input  logic                                      prod_valid,
  output logic                                      prod_ready,
  input  logic [LANES*2*DATA_WIDTH_INIT_MATRIX-1:0] product_vec,
  output logic                                      c_valid,
  input  logic                                      c_ready,
  output logic                                      matrix_c_we,
  output logic [LANES*DATA_WIDTH_RESULT_MATRIX-1:0] data_out_c,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0]      row_addr_c,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]      col_addr_c,
  output logic                                      mac_done
);

  localparam int PW  = 2*DATA_WIDTH_INIT_MATRIX;
  localparam int RW  = DATA_WIDTH_RESULT_MATRIX;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int RAW = (M > 1) ? $clog2(M) : 1;
  localparam int CAW = (N > 1) ? $clog2(N) : 1;

  logic [RW-1:0]  acc_r [LANES];
  logic [RW-1:0]  sum_s [LANES];
  logic [KW-1:0]  k_cnt_r;
  logic [RAW-1:0] row_cnt_r;
  logic [CAW-1:0] col_cnt_r;
  logic           done_pending_r;
  logic           beat_s;
  logic           k_last_s;
  logic           load_s;
  logic           wr_s;
  logic           col_wrap_s;
  logic           last_tile_s;

  function automatic logic [RW-1:0] extend(input logic [PW-1:0] p);
    logic [RW-1:0] r;
    r = RW'(p);
    for (int b = PW; b < RW; b++) begin
      r[b] = (SIGNED != 0) ? p[PW-1] : 1'b0;
    end
    return r;
  endfunction

  assign k_last_s    = (k_cnt_r == KW'(K-1));
  assign wr_s        = c_valid & c_ready;
  // Only a completing beat has to wait for the output register to free up.
  assign prod_ready  = !mac_done & !done_pending_r & !(c_valid & !c_ready & k_last_s);
  assign beat_s      = prod_valid & prod_ready;
  assign load_s      = beat_s & k_last_s;
  assign matrix_c_we = wr_s;
  assign col_wrap_s  = (col_cnt_r == CAW'(N-LANES));
  assign last_tile_s = (row_cnt_r == RAW'(M-1)) & col_wrap_s;

  // Per-lane running sum including the beat presented this cycle.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum_s[i] = acc_r[i] + extend(product_vec[i*PW +: PW]);
    end
  end

  // Accumulators, beat counter and tile position.
  always_ff @(posedge clk) begin
    if (!resetn || start) begin
      for (int i = 0; i < LANES; i++) begin
        acc_r[i] <= '0;
      end
      k_cnt_r   <= '0;
      row_cnt_r <= '0;
      col_cnt_r <= '0;
    end else if (beat_s) begin
      if (k_last_s) begin
        for (int i = 0; i < LANES; i++) begin
          acc_r[i] <= '0;
        end
        k_cnt_r <= '0;
        if (col_wrap_s) begin
          col_cnt_r <= '0;
          row_cnt_r <= row_cnt_r + RAW'(1);
        end else begin
          col_cnt_r <= col_cnt_r + CAW'(LANES);
        end
      end else begin
        for (int i = 0; i < LANES; i++) begin
          acc_r[i] <= sum_s[i];
        end
        k_cnt_r <= k_cnt_r + KW'(1);
      end
    end else begin
      k_cnt_r <= k_cnt_r;
    end
  end

  // Output tile register; a new tile may replace one being written in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn || start) begin
      data_out_c <= '0;
      row_addr_c <= '0;
      col_addr_c <= '0;
      c_valid    <= 1'b0;
    end else if (load_s) begin
      for (int i = 0; i < LANES; i++) begin
        data_out_c[i*RW +: RW] <= sum_s[i];
      end
      row_addr_c <= row_cnt_r;
      col_addr_c <= col_cnt_r;
      c_valid    <= 1'b1;
    end else if (wr_s) begin
      c_valid <= 1'b0;
    end else begin
      c_valid <= c_valid;
    end
  end

  // Completion: armed when the last tile loads, reported after its write lands.
  always_ff @(posedge clk) begin
    if (!resetn || start) begin
      done_pending_r <= 1'b0;
      mac_done       <= 1'b0;
    end else if (load_s && last_tile_s) begin
      done_pending_r <= 1'b1;
    end else if (wr_s && done_pending_r) begin
      done_pending_r <= 1'b0;
      mac_done       <= 1'b1;
    end else begin
      done_pending_r <= done_pending_r;
    end
  end

endmodule

// File: tb/tb_mac_accum_multilane.sv
// Self-checking bench for mac_accum_multilane: signed and unsigned instances share stimulus,
// checked against constants and a tile-level reference model.
module tb_mac_accum_multilane;
  localparam int M = 2, K = 4, N = 4, LANES = 2, DW = 8, PW = 16, RW = 18;
  localparam int T = M*N/LANES;

  logic clk = 1'b0;
  logic resetn, start, prod_valid, c_ready;
  logic [LANES*PW-1:0] product_vec;
  logic prod_ready_s, c_valid_s, we_s, mac_done_s;
  logic prod_ready_u, c_valid_u, we_u, mac_done_u;
  logic [LANES*RW-1:0] data_s, data_u;
  logic row_s, row_u;
  logic [1:0] col_s, col_u;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_accum_multilane #(.M(M), .K(K), .N(N), .LANES(LANES), .DATA_WIDTH_INIT_MATRIX(DW),
                        .SIGNED(1)) u_s (
    .clk(clk), .resetn(resetn), .start(start), .prod_valid(prod_valid),
    .prod_ready(prod_ready_s), .product_vec(product_vec), .c_valid(c_valid_s),
    .c_ready(c_ready), .matrix_c_we(we_s), .data_out_c(data_s), .row_addr_c(row_s),
    .col_addr_c(col_s), .mac_done(mac_done_s));

  mac_accum_multilane #(.M(M), .K(K), .N(N), .LANES(LANES), .DATA_WIDTH_INIT_MATRIX(DW),
                        .SIGNED(0)) u_u (
    .clk(clk), .resetn(resetn), .start(start), .prod_valid(prod_valid),
    .prod_ready(prod_ready_u), .product_vec(product_vec), .c_valid(c_valid_u),
    .c_ready(c_ready), .matrix_c_we(we_u), .data_out_c(data_u), .row_addr_c(row_u),
    .col_addr_c(col_u), .mac_done(mac_done_u));

  // Reference model: tiles are sums of K beats; tile index maps row-major to (row, col).
  longint        m_acc_s [LANES];
  longint        m_acc_u [LANES];
  logic [RW-1:0] m_out_s [LANES];
  logic [RW-1:0] m_out_u [LANES];
  int m_nb, m_loaded, m_written, m_row, m_col;
  bit m_pend;

  function automatic void model_clear();
    for (int i = 0; i < LANES; i++) begin
      m_acc_s[i] = 0; m_acc_u[i] = 0; m_out_s[i] = '0; m_out_u[i] = '0;
    end
    m_nb = 0; m_loaded = 0; m_written = 0; m_row = 0; m_col = 0; m_pend = 1'b0;
  endfunction

  function automatic bit model_ready(bit cr);
    return (m_loaded < T) && !(m_pend && !cr && m_nb == K-1);
  endfunction

  function automatic void model_step(bit v, bit cr, logic [LANES*PW-1:0] pv);
    bit     acc;
    longint p;
    acc = v && model_ready(cr);
    if (m_pend && cr) begin
      m_written++;
      m_pend = 1'b0;
    end
    if (acc) begin
      for (int i = 0; i < LANES; i++) begin
        p = longint'(pv[i*PW +: PW]);
        m_acc_u[i] += p;
        m_acc_s[i] += (p >= 32768) ? p - 65536 : p;
      end
      m_nb++;
      if (m_nb == K) begin
        for (int i = 0; i < LANES; i++) begin
          m_out_s[i] = RW'(m_acc_s[i]); m_out_u[i] = RW'(m_acc_u[i]);
          m_acc_s[i] = 0; m_acc_u[i] = 0;
        end
        m_row = m_loaded / (N/LANES);
        m_col = (m_loaded % (N/LANES)) * LANES;
        m_loaded++;
        m_pend = 1'b1;
        m_nb = 0;
      end
    end
  endfunction

  function automatic logic [LANES*RW-1:0] model_vec(bit uns);
    logic [LANES*RW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*RW +: RW] = uns ? m_out_u[i] : m_out_s[i];
    return v;
  endfunction

  task automatic apply(bit v, bit cr, logic [LANES*PW-1:0] pv);
    prod_valid = v; c_ready = cr; product_vec = pv;
    #1;
  endtask

  task automatic advance();
    model_step(prod_valid, c_ready, product_vec);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1; prod_valid = 1'b1; c_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; prod_valid = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; prod_valid = 1'b1; c_ready = 1'b1;
    product_vec = {16'h0005, 16'h0007};
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (c_valid_s !== 1'b0 || c_valid_u !== 1'b0 || we_s !== 1'b0) begin
      errors++; $display("FAIL reset_c_valid got %b/%b we %b exp 0", c_valid_s, c_valid_u, we_s);
    end
    checks++;
    if (data_s !== '0 || data_u !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h exp 0", data_s, data_u);
    end
    checks++;
    if (row_s !== 1'b0 || col_s !== 2'd0 || mac_done_s !== 1'b0 || mac_done_u !== 1'b0) begin
      errors++; $display("FAIL reset_addr_done got row %b col %0d done %b exp 0", row_s, col_s, mac_done_s);
    end
    resetn = 1'b1; prod_valid = 1'b0;
    model_clear();
  endtask

  task automatic test_single_tile();
    logic [LANES*RW-1:0] exp_v;
    do_start();
    for (int b = 0; b < K; b++) begin
      apply(1'b1, 1'b1, {16'(2*b+2), 16'(2*b+1)});
      checks++;
      if (prod_ready_s !== 1'b1 || c_valid_s !== 1'b0) begin
        errors++; $display("FAIL single_beat%0d got ready %b c_valid %b exp 1 0", b, prod_ready_s, c_valid_s);
      end
      advance();
    end
    exp_v = {18'd20, 18'd16};
    checks++;
    if (c_valid_s !== 1'b1 || data_s !== exp_v || row_s !== 1'b0 || col_s !== 2'd0) begin
      errors++; $display("FAIL single_tile got v %b d %h r %b c %0d exp 1 %h 0 0", c_valid_s, data_s, row_s, col_s, exp_v);
    end
    apply(1'b0, 1'b1, '0);
    advance();
    checks++;
    if (c_valid_s !== 1'b0) begin
      errors++; $display("FAIL single_drop got c_valid %b exp 0", c_valid_s);
    end
  endtask

  task automatic test_start_midtile();
    do_start();
    repeat (2) begin
      apply(1'b1, 1'b1, {16'($urandom), 16'($urandom)});
      advance();
    end
    do_start();
    for (int b = 0; b < K; b++) begin
      checks++;
      if (c_valid_s !== 1'b0) begin
        errors++; $display("FAIL start_nowrite%0d got c_valid %b exp 0", b, c_valid_s);
      end
      apply(1'b1, 1'b1, {16'd1, 16'd1});
      advance();
    end
    checks++;
    if (c_valid_s !== 1'b1 || data_s !== {18'd4, 18'd4} || row_s !== 1'b0 || col_s !== 2'd0) begin
      errors++; $display("FAIL start_tile got v %b d %h r %b c %0d exp 1 %h 0 0", c_valid_s, data_s, row_s, col_s, {18'd4, 18'd4});
    end
  endtask

  task automatic test_signed();
    do_start();
    for (int b = 0; b < K; b++) begin
      apply(1'b1, 1'b1, {(b == 0) ? 16'h8000 : 16'h0000, 16'hFFFF});
      advance();
    end
    checks++;
    if (data_s !== {18'h38000, 18'h3FFFC}) begin
      errors++; $display("FAIL signed_sum got %h exp %h", data_s, {18'h38000, 18'h3FFFC});
    end
    checks++;
    if (data_u !== {18'h08000, 18'h3FFFC}) begin
      errors++; $display("FAIL unsigned_sum got %h exp %h", data_u, {18'h08000, 18'h3FFFC});
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] p0, p1;
    longint s1 [LANES];
    longint s2 [LANES];
    logic [LANES*RW-1:0] t1, t2;
    do_start();
    for (int i = 0; i < LANES; i++) begin s1[i] = 0; s2[i] = 0; end
    for (int b = 0; b < K; b++) begin
      p0 = 16'($urandom); p1 = 16'($urandom);
      s1[0] += longint'($signed(p0)); s1[1] += longint'($signed(p1));
      apply(1'b1, 1'b0, {p1, p0});
      advance();
    end
    t1 = {RW'(s1[1]), RW'(s1[0])};
    for (int b = 0; b < K-1; b++) begin
      p0 = 16'($urandom); p1 = 16'($urandom);
      s2[0] += longint'($signed(p0)); s2[1] += longint'($signed(p1));
      apply(1'b1, 1'b0, {p1, p0});
      checks++;
      if (prod_ready_s !== 1'b1) begin
        errors++; $display("FAIL bp_overlap%0d got ready %b exp 1", b, prod_ready_s);
      end
      advance();
    end
    p0 = 16'($urandom); p1 = 16'($urandom);
    s2[0] += longint'($signed(p0)); s2[1] += longint'($signed(p1));
    t2 = {RW'(s2[1]), RW'(s2[0])};
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 1'b0, {p1, p0});
      checks++;
      if (prod_ready_s !== 1'b0 || c_valid_s !== 1'b1 || data_s !== t1 || col_s !== 2'd0) begin
        errors++; $display("FAIL bp_hold%0d got ready %b v %b d %h c %0d exp 0 1 %h 0", c, prod_ready_s, c_valid_s, data_s, col_s, t1);
      end
      advance();
    end
    apply(1'b1, 1'b1, {p1, p0});
    checks++;
    if (prod_ready_s !== 1'b1 || we_s !== 1'b1) begin
      errors++; $display("FAIL bp_release got ready %b we %b exp 1 1", prod_ready_s, we_s);
    end
    advance();
    checks++;
    if (c_valid_s !== 1'b1 || data_s !== t2 || row_s !== 1'b0 || col_s !== 2'd2) begin
      errors++; $display("FAIL bp_tile2 got v %b d %h r %b c %0d exp 1 %h 0 2", c_valid_s, data_s, row_s, col_s, t2);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int wr_idx;
    do_start();
    cyc = 0; wr_idx = 0;
    while (m_written < T && cyc < 60) begin
      checks++;
      if (c_valid_s !== m_pend || data_s !== model_vec(1'b0) || data_u !== model_vec(1'b1)) begin
        errors++; $display("FAIL b2b_out cyc %0d got v %b d %h exp %b %h", cyc, c_valid_s, data_s, m_pend, model_vec(1'b0));
      end
      apply(1'b1, 1'b1, {16'($urandom), 16'($urandom)});
      checks++;
      if (prod_ready_s !== (m_loaded < T) || we_s !== m_pend) begin
        errors++; $display("FAIL b2b_ready cyc %0d got ready %b we %b exp %b %b", cyc, prod_ready_s, we_s, m_loaded < T, m_pend);
      end
      if (we_s === 1'b1) begin
        checks++;
        if (row_s !== 1'(wr_idx / 2) || col_s !== 2'((wr_idx % 2) * 2)) begin
          errors++; $display("FAIL b2b_addr write %0d got (%0d,%0d) exp (%0d,%0d)", wr_idx, row_s, col_s, wr_idx / 2, (wr_idx % 2) * 2);
        end
        wr_idx++;
      end
      advance();
      cyc++;
    end
    checks++;
    if (m_written < T) begin
      errors++; $display("FAIL b2b_timeout got %0d writes exp %0d", m_written, T);
    end
    apply(1'b1, 1'b1, '0);
    checks++;
    if (mac_done_s !== 1'b1 || mac_done_u !== 1'b1 || prod_ready_s !== 1'b0) begin
      errors++; $display("FAIL b2b_done got done %b ready %b exp 1 0", mac_done_s, prod_ready_s);
    end
  endtask

  task automatic test_random_matrix(int runs);
    int cyc;
    bit v, cr;
    for (int r = 0; r < runs; r++) begin
      do_start();
      cyc = 0;
      while (!(m_written == T && mac_done_s === 1'b1) && cyc < 400) begin
        checks++;
        if (c_valid_s !== m_pend || c_valid_u !== m_pend || mac_done_s !== (m_written == T)) begin
          errors++; $display("FAIL rnd_state run %0d cyc %0d got v %b done %b exp %b %b", r, cyc, c_valid_s, mac_done_s, m_pend, m_written == T);
        end
        checks++;
        if (data_s !== model_vec(1'b0) || data_u !== model_vec(1'b1)) begin
          errors++; $display("FAIL rnd_data run %0d cyc %0d got %h/%h exp %h/%h", r, cyc, data_s, data_u, model_vec(1'b0), model_vec(1'b1));
        end
        if (m_pend) begin
          checks++;
          if (row_s !== m_row[0] || col_s !== m_col[1:0]) begin
            errors++; $display("FAIL rnd_addr run %0d got (%0d,%0d) exp (%0d,%0d)", r, row_s, col_s, m_row, m_col);
          end
        end
        v = ($urandom_range(9) < 7);
        cr = ($urandom_range(1) == 1);
        apply(v, cr, {16'($urandom), 16'($urandom)});
        checks++;
        if (prod_ready_s !== model_ready(cr) || prod_ready_u !== model_ready(cr) || we_s !== (m_pend && cr)) begin
          errors++; $display("FAIL rnd_ready run %0d cyc %0d got ready %b we %b exp %b %b", r, cyc, prod_ready_s, we_s, model_ready(cr), m_pend && cr);
        end
        advance();
        cyc++;
      end
      checks++;
      if (!(m_written == T && mac_done_s === 1'b1)) begin
        errors++; $display("FAIL rnd_timeout run %0d got %0d writes done %b exp %0d 1", r, m_written, mac_done_s, T);
      end
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; prod_valid = 1'b0; c_ready = 1'b0; product_vec = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_single_tile();
    test_start_midtile();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_random_matrix(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
